// File: rtl/lsu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_ctrl : load/store sequencer between the RV32I core and a req/gnt/rvalid |
// |            data memory; lane steering, load extension, misalign flagging.   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module lsu_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_mem_en,
  input  logic              i_mem_wr,
  input  logic [3:0]        i_load_type,
  input  logic              i_load_signed,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [3:0]        o_dmem_be,
  output logic [DATA_W-1:0] o_dmem_wdata,
  input  logic              i_dmem_gnt,
  input  logic              i_dmem_rvalid,
  input  logic [DATA_W-1:0] i_dmem_rdata,
  output logic              o_stall,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_misaligned
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] c_SZ_BYTE = 2'd0;
  localparam logic [1:0] c_SZ_HALF = 2'd1;
  localparam logic [1:0] c_SZ_WORD = 2'd2;

  state_t      state_q;
  logic        wr_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;

  logic [1:0]        size_d;
  logic              mis_d;
  logic [3:0]        be_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] lane_d;
  logic [DATA_W-1:0] load_d;

  // Decode of the incoming request, evaluated while IDLE.
  always_comb begin
    size_d  = c_SZ_WORD;
    mis_d   = 1'b0;
    be_d    = 4'b1111;
    wdata_d = i_wdata;
    case (i_load_type)
      4'b0001: size_d = c_SZ_BYTE;
      4'b0011: size_d = c_SZ_HALF;
      default: size_d = c_SZ_WORD;
    endcase
    case (size_d)
      c_SZ_BYTE: begin
        be_d    = 4'b0001 << i_addr[1:0];
        wdata_d = {4{i_wdata[7:0]}};
      end
      c_SZ_HALF: begin
        mis_d   = i_addr[0];
        be_d    = 4'b0011 << {i_addr[1], 1'b0};
        wdata_d = {2{i_wdata[15:0]}};
      end
      default: begin
        mis_d   = (i_addr[1:0] != 2'b00);
        be_d    = 4'b1111;
        wdata_d = i_wdata;
      end
    endcase
  end

  // Load lane extraction from the captured offset and size.
  always_comb begin
    lane_d = i_dmem_rdata >> {off_q, 3'b000};
    load_d = i_dmem_rdata;
    case (size_q)
      c_SZ_BYTE: load_d = {{(DATA_W-8){signed_q & lane_d[7]}}, lane_d[7:0]};
      c_SZ_HALF: load_d = {{(DATA_W-16){signed_q & lane_d[15]}}, lane_d[15:0]};
      default:   load_d = i_dmem_rdata;
    endcase
  end

  assign o_stall = ((state_q == S_IDLE) && i_mem_en) || (state_q == S_REQ) || (state_q == S_WAIT);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= c_SZ_WORD;
      off_q        <= 2'b00;
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_be    <= 4'b0000;
      o_dmem_wdata <= '0;
      o_done       <= 1'b0;
      o_rdata      <= '0;
      o_misaligned <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          o_done       <= 1'b0;
          o_misaligned <= 1'b0;
          if (i_mem_en) begin
            wr_q     <= i_mem_wr;
            signed_q <= i_load_signed;
            size_q   <= size_d;
            off_q    <= i_addr[1:0];
            if (mis_d) begin
              // Misaligned accesses never reach memory; report and retire.
              state_q      <= S_DONE;
              o_done       <= 1'b1;
              o_misaligned <= 1'b1;
              o_rdata      <= '0;
            end else begin
              state_q      <= S_REQ;
              o_dmem_req   <= 1'b1;
              o_dmem_we    <= i_mem_wr;
              o_dmem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
              o_dmem_be    <= be_d;
              o_dmem_wdata <= wdata_d;
            end
          end
        end
        S_REQ: begin
          if (i_dmem_gnt) begin
            o_dmem_req <= 1'b0;
            o_dmem_we  <= 1'b0;
            if (wr_q) begin
              state_q <= S_DONE;
              o_done  <= 1'b1;
              o_rdata <= '0;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (i_dmem_rvalid) begin
            state_q <= S_DONE;
            o_done  <= 1'b1;
            o_rdata <= load_d;
          end
        end
        S_DONE: begin
          state_q      <= S_IDLE;
          o_done       <= 1'b0;
          o_misaligned <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lsu_ctrl : directed transactions against a transaction-level LSU model.  |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en = 1'b0, mem_wr = 1'b0, load_signed = 1'b0;
  logic [3:0]  load_type = 4'b1111;
  logic [31:0] addr = '0, wdata = '0;
  logic        gnt = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = '0;

  logic        dmem_req, dmem_we, stall, done, misaligned;
  logic [31:0] dmem_addr, dmem_wdata, rdata_o;
  logic [3:0]  dmem_be;

  lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk(clk), .i_reset(rst), .i_mem_en(mem_en), .i_mem_wr(mem_wr),
    .i_load_type(load_type), .i_load_signed(load_signed), .i_addr(addr),
    .i_wdata(wdata), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
    .o_dmem_addr(dmem_addr), .o_dmem_be(dmem_be), .o_dmem_wdata(dmem_wdata),
    .i_dmem_gnt(gnt), .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata),
    .o_stall(stall), .o_done(done), .o_rdata(rdata_o), .o_misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: sizes in bytes, plain arithmetic.
  function automatic int nbytes(input logic [3:0] t);
    if (t == 4'b0001) return 1;
    if (t == 4'b0011) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input int n, input int off);
    int v;
    v = ((1 << n) - 1) << off;
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input int n, input logic [31:0] wd);
    if (n == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
    if (n == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input int n, input bit sg, input int off);
    logic [31:0] v, mask;
    if (n == 4) return rd;
    v    = rd >> (8 * off);
    mask = (32'd1 << (8 * n)) - 32'd1;
    v    = v & mask;
    if (sg && (((v >> (8 * n - 1)) & 32'd1) == 32'd1)) v = v | ~mask;
    return v;
  endfunction

  // Expected outputs for the current cycle, driven by the transaction tasks.
  logic        chk_on = 1'b0;
  logic        exp_stall = 1'b0, exp_req = 1'b0, exp_we = 1'b0, exp_done = 1'b0, exp_mis = 1'b0;
  logic [31:0] exp_addr = '0, exp_wd = '0, exp_rd = '0;
  logic [3:0]  exp_be = '0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("stall", {31'd0, stall}, {31'd0, exp_stall});
      check("req",   {31'd0, dmem_req}, {31'd0, exp_req});
      check("done",  {31'd0, done}, {31'd0, exp_done});
      if (exp_req) begin
        check("we",    {31'd0, dmem_we}, {31'd0, exp_we});
        check("addr",  dmem_addr, exp_addr);
        check("be",    {28'd0, dmem_be}, {28'd0, exp_be});
        check("wdata", dmem_wdata, exp_wd);
      end
      if (exp_done) begin
        check("misaligned", {31'd0, misaligned}, {31'd0, exp_mis});
        check("rdata", rdata_o, exp_rd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    mem_en = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h1234_5678;
    exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_mis = 1'b0;
  endtask

  task automatic do_access(input bit wr, input logic [3:0] lt, input bit sg,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input int gnt_dly, input int rv_dly, input bit rv_in_req);
    int  n, off;
    bit  mis;
    n   = nbytes(lt);
    off = int'(a[1:0]);
    mis = (off % n) != 0;
    mem_en = 1'b1; mem_wr = wr; load_type = lt; load_signed = sg; addr = a; wdata = wd;
    exp_stall = 1'b1; exp_req = 1'b0; exp_done = 1'b0;
    tick();
    mem_en = 1'b0;
    if (!mis) begin
      for (int k = 0; k <= gnt_dly; k++) begin
        gnt = (k == gnt_dly); rvalid = rv_in_req; rdata = 32'hBAD0_BAD0;
        exp_stall = 1'b1; exp_req = 1'b1; exp_we = wr;
        exp_addr = {a[31:2], 2'b00}; exp_be = m_be(n, off); exp_wd = m_wdata(n, wd);
        tick();
      end
      gnt = 1'b0; rvalid = 1'b0; exp_req = 1'b0;
      if (!wr) begin
        for (int k = 0; k <= rv_dly; k++) begin
          rvalid = (k == rv_dly); rdata = (k == rv_dly) ? rd : 32'h5555_AAAA;
          exp_stall = 1'b1;
          tick();
        end
        rvalid = 1'b0;
      end
    end
    exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b1; exp_mis = mis;
    exp_rd = (mis || wr) ? 32'd0 : m_load(rd, n, sg, off);
    tick();
    set_idle();
    tick();
  endtask

  initial begin
    // Pin the model against hand-computed values.
    check("pin_be_lb3",   {28'd0, m_be(1, 3)}, 32'h0000_0008);
    check("pin_be_sh2",   {28'd0, m_be(2, 2)}, 32'h0000_000C);
    check("pin_lb_s",     m_load(32'h80FF_0000, 1, 1'b1, 3), 32'hFFFF_FF80);
    check("pin_lbu",      m_load(32'h80FF_0000, 1, 1'b0, 3), 32'h0000_0080);
    check("pin_lhu",      m_load(32'hF00D_0000, 2, 1'b0, 2), 32'h0000_F00D);
    check("pin_sh_wd",    m_wdata(2, 32'h1234_ABCD), 32'hABCD_ABCD);
    check("pin_sb_wd",    m_wdata(1, 32'h0000_005A), 32'h5A5A_5A5A);

    set_idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk); #1;
    check("rst_addr",  dmem_addr, 32'd0);
    check("rst_be",    {28'd0, dmem_be}, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_mis",   {31'd0, misaligned}, 32'd0);
    check("rst_we",    {31'd0, dmem_we}, 32'd0);
    tick();

    // LW, LB/LBU, SH with delayed grant, misaligned LW/SH, LHU with early rvalid.
    do_access(1'b0, 4'b1111, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
    do_access(1'b0, 4'b0001, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 0, 1'b0);
    do_access(1'b0, 4'b0001, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 0, 1'b0);
    do_access(1'b1, 4'b0011, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 3, 0, 1'b0);
    do_access(1'b0, 4'b1111, 1'b0, 32'h0000_0101, 32'h0, 32'h0, 0, 0, 1'b0);
    do_access(1'b1, 4'b0011, 1'b0, 32'h0000_0003, 32'h0, 32'h0, 0, 0, 1'b0);
    do_access(1'b0, 4'b0011, 1'b0, 32'h0000_0002, 32'h0, 32'hF00D_0000, 1, 0, 1'b1);
    do_access(1'b0, 4'b0011, 1'b1, 32'h0000_0002, 32'h0, 32'h8001_0000, 0, 2, 1'b0);
    do_access(1'b0, 4'b0111, 1'b0, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0);

    // Reset while waiting for read data abandons the access.
    mem_en = 1'b1; mem_wr = 1'b0; load_type = 4'b1111; addr = 32'h0000_0040; wdata = 32'h0;
    exp_stall = 1'b1;
    tick();
    mem_en = 1'b0; gnt = 1'b1;
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h0000_0040; exp_be = 4'hF; exp_wd = 32'h0;
    tick();
    gnt = 1'b0; exp_req = 1'b0; exp_stall = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rvalid = 1'b1; rdata = 32'h7777_7777;
    exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0;
    tick();
    set_idle();
    tick();
    do_access(1'b1, 4'b0001, 1'b0, 32'h0000_0005, 32'h0000_005A, 32'h0, 0, 0, 1'b0);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
